// File: rtl/sonar_medidor_multicanal_if.sv
// Bus between the multichannel sonar engine and its user.
// The engine-side signals are grouped here; clock and reset stay plain ports.
interface sonar_medidor_multicanal_if #(
  parameter int N_CH   = 4,
  parameter int W_DIST = 12
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              medir;
  logic              continuo;
  logic              parar;
  logic [N_CH-1:0]   habilita;
  logic [N_CH-1:0]   echo;
  logic [N_CH-1:0]   trigger;
  logic [W_DIST-1:0] medida;
  logic [CW-1:0]     medida_canal;
  logic              medida_valida;
  logic              erro;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    output medir, continuo, parar, habilita, echo,
    input  trigger, medida, medida_canal, medida_valida, erro, pronto, db_estado
  );

  modport slave (
    input  medir, continuo, parar, habilita, echo,
    output trigger, medida, medida_canal, medida_valida, erro, pronto, db_estado
  );
endinterface

// File: rtl/sonar_medidor_multicanal.sv
// N-channel HC-SR04 engine: round-robin triggers, echo timing with rounding to cm,
// timeout detection, single-shot or continuous scanning.
module sonar_medidor_multicanal #(
  parameter int N_CH       = 4,
  parameter int W_DIST     = 12,
  parameter int TRIG_CYC   = 500,
  parameter int CM_CYC     = 2941,
  parameter int ESPERA_MAX = 1_500_000,
  parameter int ECHO_MAX   = 1_500_000,
  parameter int GAP_CYC    = 50_000
) (
  input  logic                      clock,
  input  logic                      reset,
  sonar_medidor_multicanal_if.slave bus
);

  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW     = $clog2(N_CH + 1);
  localparam int MAX_A  = (ESPERA_MAX > ECHO_MAX) ? ESPERA_MAX : ECHO_MAX;
  localparam int MAX_B  = (GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC;
  localparam int MAXC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAXC + 1);
  localparam int SUB_W  = $clog2(CM_CYC);
  localparam logic [W_DIST-1:0] DIST_NONE = {W_DIST{1'b1}};
  localparam logic [W_DIST-1:0] DIST_SAT  = DIST_NONE - W_DIST'(1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SELECIONA   = 4'd1,
    TRIGGER     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ARMAZENA    = 4'd5,
    PAUSA       = 4'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [CW-1:0]     r_ch, w_ch_nxt;
  logic [N_CH-1:0]   r_hab, w_hab_nxt;
  logic              r_cont, w_cont_nxt;
  logic              r_parar, w_parar_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [SUB_W-1:0]  r_sub, w_sub_nxt;
  logic [W_DIST-1:0] r_cm, w_cm_nxt;
  logic              r_tmo, w_tmo_nxt;
  logic [W_DIST-1:0] r_medida, w_medida_nxt;
  logic [CW-1:0]     r_canal, w_canal_nxt;
  logic              r_valida, w_valida_nxt;
  logic              r_erro, w_erro_nxt;
  logic [N_CH-1:0]   r_sync1, r_sync2, r_sync3;

  logic              w_echo, w_rise, w_found;
  logic [CW-1:0]     w_idx;
  logic [N_CH-1:0]   w_trig;

  // Distance counter holds at the last code below the "no echo" marker.
  function automatic logic [W_DIST-1:0] f_cm_inc(input logic [W_DIST-1:0] cm);
    return (cm == DIST_SAT) ? cm : cm + 1'b1;
  endfunction

  assign w_echo = r_sync2[r_ch];
  assign w_rise = r_sync2[r_ch] & ~r_sync3[r_ch];

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_hab[i] && (PW'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_idx   = CW'(i);
      end
    end
  end

  always_comb begin
    w_trig = '0;
    if (r_state == TRIGGER) w_trig[r_ch] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_ch     <= '0;
      r_hab    <= '0;
      r_cont   <= 1'b0;
      r_parar  <= 1'b0;
      r_cnt    <= '0;
      r_sub    <= '0;
      r_cm     <= '0;
      r_tmo    <= 1'b0;
      r_medida <= '0;
      r_canal  <= '0;
      r_valida <= 1'b0;
      r_erro   <= 1'b0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_ch     <= w_ch_nxt;
      r_hab    <= w_hab_nxt;
      r_cont   <= w_cont_nxt;
      r_parar  <= w_parar_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sub    <= w_sub_nxt;
      r_cm     <= w_cm_nxt;
      r_tmo    <= w_tmo_nxt;
      r_medida <= w_medida_nxt;
      r_canal  <= w_canal_nxt;
      r_valida <= w_valida_nxt;
      r_erro   <= w_erro_nxt;
      r_sync1  <= bus.echo;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_ch_nxt     = r_ch;
    w_hab_nxt    = r_hab;
    w_cont_nxt   = r_cont;
    w_parar_nxt  = r_parar | bus.parar;
    w_cnt_nxt    = r_cnt;
    w_sub_nxt    = r_sub;
    w_cm_nxt     = r_cm;
    w_tmo_nxt    = r_tmo;
    w_medida_nxt = r_medida;
    w_canal_nxt  = r_canal;
    w_valida_nxt = 1'b0;
    w_erro_nxt   = r_erro;

    unique case (r_state)
      IDLE: begin
        w_parar_nxt = 1'b0;
        // A stop request arriving with the start degrades the run to a single scan.
        if (bus.medir && (bus.habilita != '0)) begin
          w_hab_nxt   = bus.habilita;
          w_cont_nxt  = bus.continuo & ~bus.parar;
          w_ptr_nxt   = '0;
          w_state_nxt = SELECIONA;
        end
      end
      SELECIONA: begin
        if (r_parar) begin
          w_state_nxt = IDLE;
        end else if (w_found) begin
          w_ch_nxt    = w_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = TRIGGER;
        end else if (r_cont) begin
          w_ptr_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      TRIGGER: begin
        if (r_cnt == CNT_W'(TRIG_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ESPERA_ECHO;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ESPERA_ECHO: begin
        // The rising-edge cycle is the first high cycle: start one step past half a cm.
        if (w_rise) begin
          w_sub_nxt   = SUB_W'(CM_CYC / 2 + 1);
          w_cm_nxt    = '0;
          w_cnt_nxt   = CNT_W'(1);
          w_tmo_nxt   = 1'b0;
          w_state_nxt = MEDE;
        end else if (r_cnt == CNT_W'(ESPERA_MAX - 1)) begin
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ARMAZENA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      MEDE: begin
        if (!w_echo) begin
          w_state_nxt = ARMAZENA;
        end else if (r_cnt == CNT_W'(ECHO_MAX - 1)) begin
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ARMAZENA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_sub == SUB_W'(CM_CYC - 1)) begin
            w_sub_nxt = '0;
            w_cm_nxt  = f_cm_inc(r_cm);
          end else begin
            w_sub_nxt = r_sub + 1'b1;
          end
        end
      end
      ARMAZENA: begin
        w_medida_nxt = r_tmo ? DIST_NONE : r_cm;
        w_erro_nxt   = r_tmo;
        w_canal_nxt  = r_ch;
        w_valida_nxt = 1'b1;
        w_cnt_nxt    = '0;
        w_state_nxt  = PAUSA;
      end
      PAUSA: begin
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_ptr_nxt   = PW'(r_ch) + PW'(1);
          w_state_nxt = SELECIONA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.trigger       = w_trig;
  assign bus.medida        = r_medida;
  assign bus.medida_canal  = r_canal;
  assign bus.medida_valida = r_valida;
  assign bus.erro          = r_erro;
  assign bus.pronto        = (r_state == IDLE);
  assign bus.db_estado     = r_state;

endmodule
